// File: rtl/scv_vram_arb_pkg.sv
// Shared types and sizes for the VRAM port-2 arbiter.
package scv_vram_arb_pkg;
    typedef enum logic [1:0] {VA_IDLE, VA_ISSUE, VA_HOLD} vram_arb_state_t;
    localparam int VRAM_AW = 12;
    localparam int VRAM_DW = 8;
endpackage

// File: rtl/scv_rr_pick.sv
// Combinational round-robin picker with an optional sticky (locked) winner.
module scv_rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          lock_valid,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] grant,
    output logic          any
);
    always_comb begin
        int  idx;
        logic found;
        grant = ptr;
        any   = |req;
        found = 1'b0;
        idx   = 0;
        if (lock_valid && req[last]) begin
            grant = last;
            found = 1'b1;
        end
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant = IW'(idx);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/scv_vram_arb.sv
// Round-robin arbiter sharing dpram port 2 between NREQ requesters.
// Write: IDLE->ISSUE; read: IDLE->ISSUE->HOLD, RDATA/RVALID one cycle later.
module scv_vram_arb
    import scv_vram_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = VRAM_AW,
    parameter int DW   = VRAM_DW
) (
    input  logic               CLK,
    input  logic               RESB,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ-1:0]    LOCK,
    input  logic [NREQ-1:0]    WE,
    input  logic [NREQ*AW-1:0] ADDR,
    input  logic [NREQ*DW-1:0] WDATA,
    output logic [NREQ-1:0]    ACK,
    output logic [NREQ-1:0]    RVALID,
    output logic [DW-1:0]      RDATA,
    output logic [AW-1:0]      A2,
    output logic [DW-1:0]      DI2,
    output logic               nCE2,
    output logic               nWE2,
    output logic               nOE2,
    input  logic [DW-1:0]      DO2
);
    localparam int IW = $clog2(NREQ);

    vram_arb_state_t state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   last;
    logic            granted;
    logic            lat_we;
    logic [IW-1:0]   pick;
    logic            pick_any;

    // Lock only honours a requester that actually held the previous grant.
    scv_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
        .req        (REQ),
        .ptr        (ptr),
        .lock_valid (granted && LOCK[last]),
        .last       (last),
        .grant      (pick),
        .any        (pick_any)
    );

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state   <= VA_IDLE;
            ptr     <= '0;
            last    <= '0;
            granted <= 1'b0;
            lat_we  <= 1'b0;
            A2      <= '0;
            DI2     <= '0;
            nCE2    <= 1'b1;
            nWE2    <= 1'b1;
            nOE2    <= 1'b1;
            ACK     <= '0;
            RVALID  <= '0;
            RDATA   <= '0;
        end else begin
            ACK    <= '0;
            RVALID <= '0;
            case (state)
                VA_IDLE: if (pick_any) begin
                    state     <= VA_ISSUE;
                    last      <= pick;
                    granted   <= 1'b1;
                    ptr       <= (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                    lat_we    <= WE[pick];
                    A2        <= ADDR[pick*AW +: AW];
                    DI2       <= WDATA[pick*DW +: DW];
                    nCE2      <= 1'b0;
                    nWE2      <= ~WE[pick];
                    nOE2      <= WE[pick];
                    ACK[pick] <= 1'b1;
                end
                VA_ISSUE: begin
                    if (lat_we) begin
                        state <= VA_IDLE;
                        nCE2  <= 1'b1;
                        nWE2  <= 1'b1;
                    end else begin
                        state <= VA_HOLD;
                    end
                end
                VA_HOLD: begin
                    // dpram registered DO2 on the ISSUE edge; it is stable here.
                    RDATA        <= DO2;
                    RVALID[last] <= 1'b1;
                    nCE2         <= 1'b1;
                    nOE2         <= 1'b1;
                    state        <= VA_IDLE;
                end
                default: state <= VA_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scv_vram_arb.sv
// Randomised + directed bench for scv_vram_arb against a transaction-level model.
module tb_scv_vram_arb;
    localparam int NREQ = 3;
    localparam int NC   = 4096;

    logic        CLK = 1'b0;
    logic        RESB = 1'b0;
    logic [2:0]  req = '0, lock = '0, we = '0;
    logic [35:0] addr = '0;
    logic [23:0] wdata = '0;
    logic [2:0]  ACK, RVALID;
    logic [7:0]  RDATA, DI2, DO2;
    logic [11:0] A2;
    logic        nCE2, nWE2, nOE2;

    always #5 CLK = ~CLK;

    scv_vram_arb #(.NREQ(NREQ), .AW(12), .DW(8)) dut (
        .CLK(CLK), .RESB(RESB), .REQ(req), .LOCK(lock), .WE(we), .ADDR(addr),
        .WDATA(wdata), .ACK(ACK), .RVALID(RVALID), .RDATA(RDATA), .A2(A2),
        .DI2(DI2), .nCE2(nCE2), .nWE2(nWE2), .nOE2(nOE2), .DO2(DO2)
    );

    // dpram port 2: write on negedge, registered read on posedge
    logic [7:0] mem [0:4095];
    always @(negedge CLK) if (!nCE2 && !nWE2) mem[A2] <= DI2;
    always @(posedge CLK) if (!nCE2 && !nOE2) DO2 <= mem[A2];

    // model: per-cycle expected outputs, filled when a grant is decided
    logic [2:0]  e_ack [NC];
    logic [2:0]  e_rv  [NC];
    logic        e_nce [NC], e_nwe [NC], e_noe [NC], e_rdk [NC];
    logic [11:0] e_a2  [NC];
    logic [7:0]  e_di2 [NC], e_rd [NC];
    logic [7:0]  smem  [0:4095];
    bit          sk    [0:4095];
    int  m_ptr = 0, m_last = 0, free_at = 0, cyc = 0;
    bit  m_granted = 0, m_rdk = 1;
    logic [7:0] m_rd = '0;
    int  n_vec = 0, n_bad = 0;

    task automatic clr(input int k);
        e_ack[k] = '0; e_rv[k] = '0; e_nce[k] = 1; e_nwe[k] = 1; e_noe[k] = 1;
        e_a2[k] = '0; e_di2[k] = '0; e_rd[k] = '0; e_rdk[k] = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick_w(input logic [2:0] r, input logic [2:0] l);
        if (m_granted && l[m_last] && r[m_last]) return m_last;
        for (int k = 0; k < NREQ; k++)
            if (r[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic int oh2i(input logic [2:0] v);
        for (int k = 0; k < NREQ; k++) if (v[k]) return k;
        return -1;
    endfunction

    // Decide what the arbiter does with the inputs present at the end of cycle cyc.
    task automatic plan();
        int w;
        logic [11:0] a;
        logic [7:0]  d;
        if (cyc < free_at) return;
        w = pick_w(req, lock);
        if (w < 0) return;
        a = addr[w*12 +: 12];
        d = wdata[w*8 +: 8];
        m_granted = 1; m_last = w; m_ptr = (w + 1) % NREQ;
        e_ack[cyc+1] = 3'(1 << w);
        e_nce[cyc+1] = 0; e_a2[cyc+1] = a;
        if (we[w]) begin
            e_nwe[cyc+1] = 0; e_di2[cyc+1] = d;
            smem[a] = d; sk[a] = 1;
            free_at = cyc + 2;
        end else begin
            e_noe[cyc+1] = 0; e_noe[cyc+2] = 0; e_nce[cyc+2] = 0; e_a2[cyc+2] = a;
            e_rv[cyc+3] = 3'(1 << w); e_rd[cyc+3] = smem[a]; e_rdk[cyc+3] = sk[a];
            free_at = cyc + 3;
        end
    endtask

    task automatic check();
        if (e_rv[cyc] != 0) begin m_rd = e_rd[cyc]; m_rdk = e_rdk[cyc]; end
        chk("ack", 32'(ACK), 32'(e_ack[cyc]));
        chk("rvalid", 32'(RVALID), 32'(e_rv[cyc]));
        chk("nce2", 32'(nCE2), 32'(e_nce[cyc]));
        chk("nwe2", 32'(nWE2), 32'(e_nwe[cyc]));
        chk("noe2", 32'(nOE2), 32'(e_noe[cyc]));
        chk("overlap", 32'((|ACK) && (|RVALID)), 32'(0));
        if (!e_nce[cyc]) chk("a2", 32'(A2), 32'(e_a2[cyc]));
        if (!e_nwe[cyc]) chk("di2", 32'(DI2), 32'(e_di2[cyc]));
        if (m_rdk) chk("rdata", 32'(RDATA), 32'(m_rd));
    endtask

    task automatic tick();
        plan();
        @(posedge CLK); #1;
        cyc++;
        check();
    endtask

    int g [8];
    int gc [8];
    int ng, n1, noe;
    int exp4 [6] = '{0, 1, 1, 1, 1, 2};

    initial begin
        for (int k = 0; k < NC; k++) clr(k);
        for (int k = 0; k < 4096; k++) begin smem[k] = '0; sk[k] = 0; end
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_nce2", 32'(nCE2), 1); chk("rst_nwe2", 32'(nWE2), 1);
        chk("rst_noe2", 32'(nOE2), 1); chk("rst_ack", 32'(ACK), 0);
        chk("rst_rvalid", 32'(RVALID), 0); chk("rst_rdata", 32'(RDATA), 0);
        chk("rst_a2", 32'(A2), 0); chk("rst_di2", 32'(DI2), 0);
        RESB = 1'b1;

        // 1: write 5A @123 from req0
        req = 3'b001; we = 3'b001; addr[11:0] = 12'h123; wdata[7:0] = 8'h5A;
        tick(); chk("t1_ack", 32'(ACK), 32'b001);
        req = '0;
        tick(); chk("t1_port1", 32'(mem[12'h123]), 32'h5A);

        // 2: read @123 from req2
        req = 3'b100; we = 3'b000; addr[35:24] = 12'h123;
        tick(); chk("t2_ack", 32'(ACK), 32'b100);
        noe = int'(!nOE2); req = '0;
        tick(); noe += int'(!nOE2);
        tick(); noe += int'(!nOE2);
        chk("t2_rvalid", 32'(RVALID), 32'b100); chk("t2_rdata", 32'(RDATA), 32'h5A);
        tick(); noe += int'(!nOE2);
        chk("t2_noe_cycles", 32'(noe), 2);

        // 3: all requesting writes, no lock
        for (int i = 0; i < 3; i++) begin addr[i*12 +: 12] = 12'h200 + 12'(i); wdata[i*8 +: 8] = 8'h30 + 8'(i); end
        req = 3'b111; we = 3'b111; lock = '0; ng = 0;
        for (int t = 0; t < 11; t++) begin
            tick();
            if (ACK != 0 && ng < 8) begin g[ng] = oh2i(ACK); gc[ng] = cyc; ng++; end
        end
        req = '0; tick(); tick();
        chk("t3_count", 32'(ng), 6);
        for (int k = 0; k < 6 && k < ng; k++) chk("t3_order", 32'(g[k]), 32'(k % 3));
        for (int k = 1; k < 6 && k < ng; k++) chk("t3_spacing", 32'(gc[k] - gc[k-1]), 2);

        // 4: req1 locks for four grants
        req = 3'b111; lock = 3'b010; ng = 0; n1 = 0;
        for (int t = 0; t < 24 && ng < 6; t++) begin
            tick();
            if (ACK != 0) begin
                g[ng] = oh2i(ACK); ng++;
                if (g[ng-1] == 1) n1++;
                if (n1 == 4) lock = '0;
                if (ng == 6) req = '0;
            end
        end
        req = '0; lock = '0; tick(); tick();
        chk("t4_count", 32'(ng), 6);
        for (int k = 0; k < 6 && k < ng; k++) chk("t4_order", 32'(g[k]), 32'(exp4[k]));

        // 5: reset during ISSUE of a write
        req = 3'b001; we = 3'b111; addr[11:0] = 12'h007; wdata[7:0] = 8'h11;
        tick(); chk("t5_ack", 32'(ACK), 32'b001);
        #1 RESB = 1'b0;
        #1;
        chk("t5_nce2", 32'(nCE2), 1); chk("t5_nwe2", 32'(nWE2), 1); chk("t5_ack_gone", 32'(ACK), 0);
        for (int k = cyc + 1; k <= cyc + 3; k++) clr(k);
        m_ptr = 0; m_granted = 0; m_last = 0; free_at = cyc; m_rd = '0; m_rdk = 1; sk[12'h007] = 0;
        req = 3'b110;
        #1 RESB = 1'b1;
        tick(); chk("t5_first_grant", 32'(ACK), 32'b010);
        req = '0; tick(); tick();

        // 6: read from req0, write from req1 raised in HOLD
        req = 3'b001; we = 3'b010; addr[11:0] = 12'h123; addr[23:12] = 12'h055; wdata[15:8] = 8'hC3;
        tick(); chk("t6_ack0", 32'(ACK), 32'b001);
        req = '0;
        tick(); req = 3'b010;
        tick(); chk("t6_rvalid", 32'(RVALID), 32'b001); chk("t6_noack", 32'(ACK), 0);
        chk("t6_rdata", 32'(RDATA), 32'h5A);
        tick(); chk("t6_ack1", 32'(ACK), 32'b010); chk("t6_norv", 32'(RVALID), 0);
        req = '0;
        tick(); chk("t6_rdata_kept", 32'(RDATA), 32'h5A);
        tick();

        // random traffic
        lock = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (e_ack[cyc][i] || (!req[i] && $urandom_range(0, 9) < 3)) begin
                    if (e_ack[cyc][i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else begin
                        req[i] = 1'b1;
                        we[i] = 1'($urandom_range(0, 1));
                        addr[i*12 +: 12] = 12'h300 + 12'($urandom_range(0, 15));
                        wdata[i*8 +: 8] = 8'($urandom);
                    end
                end else if (req[i] && $urandom_range(0, 99) < 3) begin
                    req[i] = 1'b0;
                end
                lock[i] = ($urandom_range(0, 4) == 0);
            end
            tick();
        end
        req = '0; lock = '0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
